// File: rtl/pzcorebus_error_responder.sv
// Default slave for pzcorebus: accepts every command, drains write data and answers with error responses.
// Optional saturating command counter when PZCOREBUS_ERROR_RESPONDER_COUNTER_EN is defined.
module pzcorebus_error_responder #(
    parameter int                    ID_WIDTH     = 8,
    parameter int                    LENGTH_WIDTH = 4,
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] ERROR_DATA   = 32'hDEAD_BEEF
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_mcmd_valid,
    output logic                    o_scmd_accept,
    input  logic [1:0]              i_mcmd,
    input  logic [ID_WIDTH-1:0]     i_mid,
    input  logic [LENGTH_WIDTH-1:0] i_mlength,
    input  logic                    i_mdata_valid,
    output logic                    o_sdata_accept,
    input  logic                    i_mdata_last,
    output logic                    o_sresp_valid,
    input  logic                    i_mresp_accept,
    output logic                    o_sresp,
    output logic [ID_WIDTH-1:0]     o_sid,
    output logic                    o_serror,
    output logic [DATA_WIDTH-1:0]   o_sdata,
    output logic                    o_sresp_last
`ifdef PZCOREBUS_ERROR_RESPONDER_COUNTER_EN
    ,
    output logic [15:0]             o_error_count,
    input  logic                    i_error_count_clear
`endif
);

    localparam logic [1:0] CMD_READ         = 2'd0;
    localparam logic [1:0] CMD_WRITE        = 2'd1;
    localparam logic [1:0] CMD_POSTED_WRITE = 2'd2;
    localparam logic [1:0] CMD_MESSAGE      = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WDATA = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic                    scmd_accept_q, scmd_accept_d;
    logic                    sresp_valid_q, sresp_valid_d;
    logic                    sresp_q, sresp_d;
    logic [ID_WIDTH-1:0]     sid_q, sid_d;
    logic [DATA_WIDTH-1:0]   sdata_q, sdata_d;
    logic                    sresp_last_q, sresp_last_d;
    logic [LENGTH_WIDTH-1:0] count_q, count_d;
    logic                    posted_q, posted_d;
    logic                    cmd_hs;

    assign cmd_hs = i_mcmd_valid && scmd_accept_q;

    always_comb begin
        state_d       = state_q;
        sresp_valid_d = sresp_valid_q;
        sresp_d       = sresp_q;
        sid_d         = sid_q;
        sdata_d       = sdata_q;
        sresp_last_d  = sresp_last_q;
        count_d       = count_q;
        posted_d      = posted_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_hs) begin
                    sid_d   = i_mid;
                    count_d = i_mlength;
                    case (i_mcmd)
                        CMD_READ: begin
                            state_d       = ST_RESP;
                            sresp_valid_d = 1'b1;
                            sresp_d       = 1'b1;
                            sdata_d       = ERROR_DATA;
                            sresp_last_d  = (i_mlength == '0);
                        end
                        CMD_MESSAGE: begin
                            state_d       = ST_RESP;
                            sresp_valid_d = 1'b1;
                            sresp_d       = 1'b0;
                            sdata_d       = '0;
                            sresp_last_d  = 1'b1;
                        end
                        default: begin
                            state_d  = ST_WDATA;
                            posted_d = (i_mcmd == CMD_POSTED_WRITE);
                        end
                    endcase
                end
            end
            ST_WDATA: begin
                // Beat count is not checked against mlength; only the last flag ends the burst.
                if (i_mdata_valid && i_mdata_last) begin
                    if (posted_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d       = ST_RESP;
                        sresp_valid_d = 1'b1;
                        sresp_d       = 1'b0;
                        sdata_d       = '0;
                        sresp_last_d  = 1'b1;
                    end
                end
            end
            ST_RESP: begin
                // sresp_valid is always high here, so the accept alone completes a beat.
                if (i_mresp_accept) begin
                    if (sresp_q && (count_q != '0)) begin
                        count_d      = count_q - 1'b1;
                        sresp_last_d = (count_q == LENGTH_WIDTH'(1));
                    end else begin
                        state_d       = ST_IDLE;
                        sresp_valid_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d       = ST_IDLE;
                sresp_valid_d = 1'b0;
            end
        endcase

        scmd_accept_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= ST_IDLE;
            scmd_accept_q <= 1'b0;
            sresp_valid_q <= 1'b0;
            sresp_q       <= 1'b0;
            sid_q         <= '0;
            sdata_q       <= '0;
            sresp_last_q  <= 1'b0;
            count_q       <= '0;
            posted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            scmd_accept_q <= scmd_accept_d;
            sresp_valid_q <= sresp_valid_d;
            sresp_q       <= sresp_d;
            sid_q         <= sid_d;
            sdata_q       <= sdata_d;
            sresp_last_q  <= sresp_last_d;
            count_q       <= count_d;
            posted_q      <= posted_d;
        end
    end

    assign o_scmd_accept  = scmd_accept_q;
    assign o_sdata_accept = (state_q == ST_WDATA);
    assign o_sresp_valid  = sresp_valid_q;
    assign o_sresp        = sresp_q;
    assign o_sid          = sid_q;
    assign o_serror       = sresp_valid_q;
    assign o_sdata        = sdata_q;
    assign o_sresp_last   = sresp_last_q;

`ifdef PZCOREBUS_ERROR_RESPONDER_COUNTER_EN
    logic [15:0] error_count_q, error_count_d;

    always_comb begin
        error_count_d = error_count_q;
        if (i_error_count_clear) begin
            error_count_d = '0;
        end else if (cmd_hs && (error_count_q != 16'hFFFF)) begin
            error_count_d = error_count_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            error_count_q <= '0;
        end else begin
            error_count_q <= error_count_d;
        end
    end

    assign o_error_count = error_count_q;
`endif

endmodule

// File: tb/tb_pzcorebus_error_responder.sv
// Bench for pzcorebus_error_responder: vector table, hand sequences and random transactions
// checked against a response-beat model.
module tb_pzcorebus_error_responder;

    localparam int          PW      = 42;
    localparam logic [31:0] ERR     = 32'hDEAD_BEEF;
    localparam logic [1:0]  C_READ  = 2'd0;
    localparam logic [1:0]  C_WRITE = 2'd1;
    localparam logic [1:0]  C_POST  = 2'd2;
    localparam logic [1:0]  C_MSG   = 2'd3;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_mcmd_valid = 1'b0;
    logic        o_scmd_accept;
    logic [1:0]  i_mcmd = 2'd0;
    logic [7:0]  i_mid = 8'd0;
    logic [3:0]  i_mlength = 4'd0;
    logic        i_mdata_valid = 1'b0;
    logic        o_sdata_accept;
    logic        i_mdata_last = 1'b0;
    logic        o_sresp_valid;
    logic        i_mresp_accept = 1'b0;
    logic        o_sresp;
    logic [7:0]  o_sid;
    logic        o_serror;
    logic [31:0] o_sdata;
    logic        o_sresp_last;
`ifdef PZCOREBUS_ERROR_RESPONDER_COUNTER_EN
    logic [15:0] o_error_count;
    logic        i_error_count_clear = 1'b0;
`endif

    pzcorebus_error_responder #(
        .ID_WIDTH    (8),
        .LENGTH_WIDTH(4),
        .DATA_WIDTH  (32),
        .ERROR_DATA  (ERR)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_mcmd_valid  (i_mcmd_valid),
        .o_scmd_accept (o_scmd_accept),
        .i_mcmd        (i_mcmd),
        .i_mid         (i_mid),
        .i_mlength     (i_mlength),
        .i_mdata_valid (i_mdata_valid),
        .o_sdata_accept(o_sdata_accept),
        .i_mdata_last  (i_mdata_last),
        .o_sresp_valid (o_sresp_valid),
        .i_mresp_accept(i_mresp_accept),
        .o_sresp       (o_sresp),
        .o_sid         (o_sid),
        .o_serror      (o_serror),
        .o_sdata       (o_sdata),
        .o_sresp_last  (o_sresp_last)
`ifdef PZCOREBUS_ERROR_RESPONDER_COUNTER_EN
        ,
        .o_error_count      (o_error_count),
        .i_error_count_clear(i_error_count_clear)
`endif
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;
    int unsigned cmd_model = 0;
    logic [PW-1:0] exp_q[$];

    typedef struct {
        logic [1:0] cmd;
        logic [7:0] id;
        logic [3:0] len;
        int         ndata;
        int         gap;
        int         mode;
        int         exp_beats;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input logic [63:0] act, input logic [63:0] exp, input string name);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expected response beats {sresp, sid, sdata, last} for one command.
    function automatic void build_exp(input logic [1:0] cmd, input logic [7:0] id, input logic [3:0] len);
        if (cmd == C_READ) begin
            for (int b = 0; b <= int'(len); b++)
                exp_q.push_back({1'b1, id, ERR, (b == int'(len))});
        end else if (cmd != C_POST) begin
            exp_q.push_back({1'b0, id, 32'h0, 1'b1});
        end
    endfunction

    task automatic send_cmd(input logic [1:0] cmd, input logic [7:0] id, input logic [3:0] len);
        int n = 0;
        i_mcmd_valid = 1'b1;
        i_mcmd       = cmd;
        i_mid        = id;
        i_mlength    = len;
        while (!o_scmd_accept && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        chk(o_scmd_accept, 1, "scmd_accept");
        @(negedge i_clk);
        i_mcmd_valid = 1'b0;
        i_mcmd       = 2'($urandom);
        if (cmd_model < 65535) cmd_model++;
        chk(o_scmd_accept, 0, "scmd_accept_drop");
    endtask

    task automatic send_data(input int n, input int gap);
        for (int b = 0; b < n; b++) begin
            if (b == gap && b > 0) begin
                i_mdata_valid = 1'b0;
                @(negedge i_clk);
            end
            i_mdata_valid = 1'b1;
            i_mdata_last  = (b == n - 1);
            chk(o_sdata_accept, 1, "sdata_accept");
            @(negedge i_clk);
        end
        i_mdata_valid = 1'b0;
        i_mdata_last  = 1'b0;
    endtask

    task automatic collect(input int mode, input int exp_beats);
        int   cyc = 0;
        int   nb  = 0;
        logic tog = 1'b1;
        logic acc;
        forever begin
            chk(o_serror, o_sresp_valid, "serror");
            if (exp_q.size() == 0) begin
                chk(o_sresp_valid, 0, "resp_valid_idle");
            end else begin
                chk(o_sresp_valid, 1, "resp_valid_pending");
                if (o_sresp_valid)
                    chk({o_sresp, o_sid, o_sdata, o_sresp_last}, exp_q[0], "resp_payload");
            end
            if ((exp_q.size() == 0 && !o_sresp_valid && cyc >= 2) || cyc >= 300) break;
            acc = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
            tog = ~tog;
            i_mresp_accept = acc;
            if (o_sresp_valid && acc) begin
                nb++;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            @(negedge i_clk);
            cyc++;
        end
        i_mresp_accept = 1'b0;
        chk(exp_q.size(), 0, "resp_drain");
        chk(nb, exp_beats, "beat_count");
        chk(o_scmd_accept, 1, "scmd_accept_return");
        exp_q.delete();
    endtask

    task automatic run_txn(input logic [1:0] cmd, input logic [7:0] id, input logic [3:0] len,
                           input int ndata, input int gap, input int mode, input int exp_beats);
        build_exp(cmd, id, len);
        send_cmd(cmd, id, len);
        if (cmd == C_WRITE || cmd == C_POST) send_data(ndata, gap);
        collect(mode, exp_beats);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk(o_scmd_accept,  0, {tag, "_scmd_accept"});
        chk(o_sdata_accept, 0, {tag, "_sdata_accept"});
        chk(o_sresp_valid,  0, {tag, "_sresp_valid"});
        chk(o_sresp,        0, {tag, "_sresp"});
        chk(o_sid,          0, {tag, "_sid"});
        chk(o_serror,       0, {tag, "_serror"});
        chk(o_sdata,        0, {tag, "_sdata"});
        chk(o_sresp_last,   0, {tag, "_sresp_last"});
    endtask

    task automatic pulse_reset();
        i_rst = 1'b1;
        #1;
        check_reset_outputs("rst_pulse");
        cmd_model = 0;
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        chk(o_scmd_accept, 1, "scmd_accept_after_rst");
    endtask

    initial begin
        vecs[0] = '{cmd: C_READ,  id: 8'h5A, len: 4'd3, ndata: 0, gap: 0, mode: 0, exp_beats: 4};
        vecs[1] = '{cmd: C_WRITE, id: 8'h11, len: 4'd2, ndata: 3, gap: 1, mode: 0, exp_beats: 1};
        vecs[2] = '{cmd: C_POST,  id: 8'h22, len: 4'd1, ndata: 2, gap: 0, mode: 0, exp_beats: 0};
        vecs[3] = '{cmd: C_READ,  id: 8'h33, len: 4'hF, ndata: 0, gap: 0, mode: 1, exp_beats: 16};
        vecs[4] = '{cmd: C_MSG,   id: 8'h44, len: 4'd0, ndata: 0, gap: 0, mode: 2, exp_beats: 1};
        vecs[5] = '{cmd: C_READ,  id: 8'h66, len: 4'd0, ndata: 0, gap: 0, mode: 2, exp_beats: 1};

        repeat (2) @(negedge i_clk);
        check_reset_outputs("reset");
        i_rst = 1'b0;
        chk(o_scmd_accept, 0, "scmd_accept_pre_edge");
        @(negedge i_clk);
        chk(o_scmd_accept, 1, "scmd_accept_first_edge");

        // Write data offered before any command must be stalled.
        i_mdata_valid = 1'b1;
        i_mdata_last  = 1'b1;
        repeat (2) begin
            chk(o_sdata_accept, 0, "early_data_stall");
            @(negedge i_clk);
        end
        i_mdata_valid = 1'b0;
        i_mdata_last  = 1'b0;
        chk(o_sresp_valid, 0, "early_data_no_resp");

        for (int v = 0; v < 6; v++)
            run_txn(vecs[v].cmd, vecs[v].id, vecs[v].len, vecs[v].ndata,
                    vecs[v].gap, vecs[v].mode, vecs[v].exp_beats);

        // Reset in the middle of a read burst drops it.
        send_cmd(C_READ, 8'h77, 4'd3);
        i_mresp_accept = 1'b1;
        @(negedge i_clk);
        i_mresp_accept = 1'b0;
        chk(o_sresp_valid, 1, "burst_beat2_valid");
        chk(o_sresp_last, 0, "burst_beat2_last");
        pulse_reset();
        repeat (2) begin
            @(negedge i_clk);
            chk(o_sresp_valid, 0, "burst_dropped");
        end
        run_txn(C_MSG, 8'h01, 4'd0, 0, 0, 0, 1);

        for (int r = 0; r < 30; r++) begin
            logic [1:0] cmd;
            logic [3:0] len;
            int nd;
            cmd = 2'($urandom_range(0, 3));
            len = 4'($urandom_range(0, 15));
            nd  = $urandom_range(1, 4);
            run_txn(cmd, 8'($urandom), len, nd, $urandom_range(0, nd - 1), $urandom_range(0, 2),
                    (cmd == C_READ) ? int'(len) + 1 : (cmd == C_POST) ? 0 : 1);
        end

`ifdef PZCOREBUS_ERROR_RESPONDER_COUNTER_EN
        chk(o_error_count, cmd_model, "error_count_random");
        pulse_reset();
        chk(o_error_count, 0, "error_count_reset");
        for (int k = 0; k < 3; k++) run_txn(C_MSG, 8'(k), 4'd0, 0, 0, 0, 1);
        chk(o_error_count, 3, "error_count_three");
        build_exp(C_MSG, 8'h04, 4'd0);
        i_error_count_clear = 1'b1;
        send_cmd(C_MSG, 8'h04, 4'd0);
        i_error_count_clear = 1'b0;
        chk(o_error_count, 0, "error_count_clear_wins");
        collect(0, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
